msi_bus_responder: RTL and testbench

- Shared snoop-bus responder for the two-core MSI system.
- Each core's cache controller raises read_miss, write_miss, invalidate or writeback (u_we).
- This block arbitrates between the cores and returns grant.
- It broadcasts the request to the other core's cache as a snoop (cpu_search, snoop address, invalidate).
- Data comes from the snooping cache or from unified memory; the block completes each transaction with a one-cycle u_rdy pulse and response word.

---
 rtl/msi_bus_responder_pkg.sv | 8 +
 rtl/msi_bus_responder_arbiter.sv | 28 ++
 rtl/msi_bus_responder.sv | 141 ++++++++++++++
 tb/tb_msi_bus_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/msi_bus_responder_pkg.sv
// msi_bus_responder_pkg: request and FSM encodings shared by the MSI snoop-bus responder and its arbiter.
package msi_bus_responder_pkg;
    typedef enum logic [2:0] {REQ_NONE, REQ_WB, REQ_WR_MISS, REQ_RD_MISS, REQ_INVAL} bus_req_t;
    typedef enum logic [2:0] {ST_IDLE, ST_SNOOP, ST_SNOOP_WAIT, ST_MEM_RD, ST_MEM_WR, ST_RESP} bus_state_t;
    function automatic bus_req_t pick_req(input logic wb, input logic wr, input logic rd, input logic inv);
        return wb ? REQ_WB : wr ? REQ_WR_MISS : rd ? REQ_RD_MISS : inv ? REQ_INVAL : REQ_NONE;
    endfunction
endpackage

// File: rtl/msi_bus_responder_arbiter.sv
// msi_rr_arbiter: 2-way round-robin core select plus per-core request-type priority (wb > wr_miss > rd_miss > inval).
module msi_rr_arbiter
    import msi_bus_responder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_rd_miss,
    input  logic [1:0] i_wr_miss,
    input  logic [1:0] i_inval,
    input  logic [1:0] i_wb,
    input  logic       i_take,
    output logic       o_valid,
    output logic       o_core,
    output bus_req_t   o_type
);
    logic       r_last;
    logic       w_core;
    logic [1:0] w_has;
    assign w_has   = i_rd_miss | i_wr_miss | i_inval | i_wb;
    // on a tie the core that was not granted last wins
    assign w_core  = (&w_has) ? ~r_last : w_has[1];
    assign o_valid = |w_has;
    assign o_core  = w_core;
    assign o_type  = pick_req(i_wb[w_core], i_wr_miss[w_core], i_rd_miss[w_core], i_inval[w_core]);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_last <= 1'b1;
        else if (i_take) r_last <= w_core;
endmodule

// File: rtl/msi_bus_responder.sv
// msi_bus_responder: two-core MSI snoop-bus responder (arbitrate, snoop, memory fill/writeback, respond).
// Define SHARE_WRITEBACK_EN to also write snoop-hit read-miss data back to memory.
module msi_bus_responder
    import msi_bus_responder_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        i_req_rd_miss,
    input  logic [1:0]        i_req_wr_miss,
    input  logic [1:0]        i_req_inval,
    input  logic [1:0]        i_req_wb,
    input  logic [ADDR_W-1:0] i_req_addr0,
    input  logic [ADDR_W-1:0] i_req_addr1,
    input  logic [DATA_W-1:0] i_req_wdata0,
    input  logic [DATA_W-1:0] i_req_wdata1,
    output logic [1:0]        o_grant,
    output logic [1:0]        o_u_rdy,
    output logic [DATA_W-1:0] o_resp_data,
    output logic [1:0]        o_cpu_search,
    output logic [1:0]        o_snoop_inval,
    output logic [ADDR_W-1:0] o_snoop_addr,
    input  logic [1:0]        i_snoop_found,
    input  logic [DATA_W-1:0] i_snoop_data0,
    input  logic [DATA_W-1:0] i_snoop_data1,
    output logic              o_mem_re,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_rdy
);
`ifdef SHARE_WRITEBACK_EN
    localparam logic SHARE_WB = 1'b1;
`else
    localparam logic SHARE_WB = 1'b0;
`endif
    bus_state_t        r_state, w_next;
    bus_req_t          r_type, w_type;
    logic              r_core, w_core, w_valid, w_take, w_other, w_found;
    logic [1:0]        r_grant;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_resp, w_snoop_data;

    msi_rr_arbiter u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rd_miss (i_req_rd_miss),
        .i_wr_miss (i_req_wr_miss),
        .i_inval   (i_req_inval),
        .i_wb      (i_req_wb),
        .i_take    (w_take),
        .o_valid   (w_valid),
        .o_core    (w_core),
        .o_type    (w_type)
    );

    assign w_take       = (r_state == ST_IDLE) && w_valid;
    assign w_other      = ~r_core;
    assign w_found      = i_snoop_found[w_other];
    assign w_snoop_data = w_other ? i_snoop_data1 : i_snoop_data0;
    assign o_grant      = r_grant;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= ST_IDLE;
        else r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:       w_next = w_take ? ((w_type == REQ_WB) ? ST_MEM_WR : ST_SNOOP) : ST_IDLE;
            ST_SNOOP:      w_next = (r_type == REQ_INVAL) ? ST_RESP : ST_SNOOP_WAIT;
            ST_SNOOP_WAIT: w_next = !w_found ? ST_MEM_RD : (SHARE_WB && r_type == REQ_RD_MISS) ? ST_MEM_WR : ST_RESP;
            ST_MEM_RD,
            ST_MEM_WR:     w_next = i_mem_rdy ? ST_RESP : r_state;
            ST_RESP:       w_next = ST_IDLE;
            default:       w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_cpu_search  = 2'b00;
        o_snoop_inval = 2'b00;
        o_snoop_addr  = '0;
        o_mem_re      = 1'b0;
        o_mem_we      = 1'b0;
        o_mem_addr    = '0;
        o_mem_wdata   = '0;
        o_u_rdy       = 2'b00;
        o_resp_data   = '0;
        case (r_state)
            ST_SNOOP: begin
                o_cpu_search[w_other]  = 1'b1;
                o_snoop_inval[w_other] = (r_type == REQ_WR_MISS) || (r_type == REQ_INVAL);
                o_snoop_addr           = r_addr;
            end
            ST_MEM_RD: begin
                o_mem_re   = 1'b1;
                o_mem_addr = r_addr;
            end
            ST_MEM_WR: begin
                o_mem_we    = 1'b1;
                o_mem_addr  = r_addr;
                o_mem_wdata = r_wdata;
            end
            ST_RESP: begin
                o_u_rdy[r_core] = 1'b1;
                o_resp_data     = r_resp;
            end
            default: ;
        endcase
    end

    // r_resp is cleared on grant so writebacks and invalidates answer with zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant <= 2'b00;
            r_core  <= 1'b0;
            r_type  <= REQ_NONE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_resp  <= '0;
        end else begin
            r_grant <= w_take ? {w_core, ~w_core} : 2'b00;
            if (w_take) begin
                r_core  <= w_core;
                r_type  <= w_type;
                r_addr  <= w_core ? i_req_addr1 : i_req_addr0;
                r_wdata <= w_core ? i_req_wdata1 : i_req_wdata0;
                r_resp  <= '0;
            end
            if (r_state == ST_SNOOP_WAIT && w_found) begin
                r_resp <= w_snoop_data;
                if (SHARE_WB && r_type == REQ_RD_MISS) r_wdata <= w_snoop_data;
            end
            if (r_state == ST_MEM_RD && i_mem_rdy) r_resp <= i_mem_rdata;
        end
    end
endmodule

// File: tb/tb_msi_bus_responder.sv
// tb_msi_bus_responder: directed vector table plus hand-written tie, wb+rd and async-reset sequences.
module tb_msi_bus_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  i_req_rd_miss, i_req_wr_miss, i_req_inval, i_req_wb;
    logic [12:0] i_req_addr0, i_req_addr1;
    logic [15:0] i_req_wdata0, i_req_wdata1;
    logic [1:0]  o_grant, o_u_rdy, o_cpu_search, o_snoop_inval;
    logic [15:0] o_resp_data;
    logic [12:0] o_snoop_addr, o_mem_addr;
    logic [1:0]  i_snoop_found;
    logic [15:0] i_snoop_data0, i_snoop_data1, o_mem_wdata, i_mem_rdata;
    logic        o_mem_re, o_mem_we, i_mem_rdy;

    msi_bus_responder dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_rd_miss(i_req_rd_miss), .i_req_wr_miss(i_req_wr_miss),
        .i_req_inval(i_req_inval), .i_req_wb(i_req_wb),
        .i_req_addr0(i_req_addr0), .i_req_addr1(i_req_addr1),
        .i_req_wdata0(i_req_wdata0), .i_req_wdata1(i_req_wdata1),
        .o_grant(o_grant), .o_u_rdy(o_u_rdy), .o_resp_data(o_resp_data),
        .o_cpu_search(o_cpu_search), .o_snoop_inval(o_snoop_inval), .o_snoop_addr(o_snoop_addr),
        .i_snoop_found(i_snoop_found), .i_snoop_data0(i_snoop_data0), .i_snoop_data1(i_snoop_data1),
        .o_mem_re(o_mem_re), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_rdy(i_mem_rdy)
    );

    always #5 clk = ~clk;

    // kind = {wb, wr_miss, rd_miss, inval}; e_lat = cycle of u_rdy counting the request cycle as 0
    typedef struct {
        logic        core;
        logic [3:0]  kind;
        logic [12:0] addr;
        logic [15:0] wdata;
        logic        found;
        logic [15:0] sdata;
        int          mwait;
        logic [15:0] mdata;
        logic [1:0]  e_grant, e_search, e_inval;
        logic        e_re, e_we;
        logic [15:0] e_wdata;
        int          e_lat;
        logic [15:0] e_resp;
    } vec_t;

    vec_t        vecs [7];
    int          n_cmp = 0, n_bad = 0, cyc = 0;
    int          g_cnt, s_cnt, u_cnt, mcount = 0, cfg_mwait = 0;
    logic [1:0]  g_val [4], u_val [4];
    int          g_cyc [4], u_cyc [4];
    logic [15:0] u_data [4];
    logic [1:0]  s_val, s_inv, prev_search = 2'b00;
    logic [12:0] s_addr, m_addr;
    logic [15:0] m_wdata, cfg_sdata = 16'h0, cfg_mdata = 16'h0;
    logic        re_seen, we_seen, cfg_found = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        cyc = 0; g_cnt = 0; s_cnt = 0; u_cnt = 0;
        s_val = 2'b00; s_inv = 2'b00; s_addr = '0; m_addr = '0; m_wdata = '0;
        re_seen = 1'b0; we_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            g_val[k] = 2'b00; u_val[k] = 2'b00; g_cyc[k] = -1; u_cyc[k] = -1; u_data[k] = 16'h0;
        end
    endtask

    task automatic drop(input int c);
        if (i_req_wb[c]) i_req_wb[c] = 1'b0;
        else if (i_req_wr_miss[c]) i_req_wr_miss[c] = 1'b0;
        else if (i_req_rd_miss[c]) i_req_rd_miss[c] = 1'b0;
        else i_req_inval[c] = 1'b0;
    endtask

    // one clock: sample outputs at negedge, then play snooping cache, memory and requesting cores
    task automatic tick();
        @(negedge clk);
        cyc++;
        chk("mem_exclusive", 32'(o_mem_re & o_mem_we), 32'h0);
        if (o_grant != 2'b00) begin
            if (g_cnt < 4) begin g_val[g_cnt] = o_grant; g_cyc[g_cnt] = cyc; end
            g_cnt++;
        end
        s_inv |= o_snoop_inval;
        if (o_cpu_search != 2'b00) begin s_cnt++; s_val |= o_cpu_search; s_addr = o_snoop_addr; end
        if (o_mem_re) begin re_seen = 1'b1; m_addr = o_mem_addr; end
        if (o_mem_we) begin we_seen = 1'b1; m_addr = o_mem_addr; m_wdata = o_mem_wdata; end
        if (o_u_rdy != 2'b00) begin
            if (u_cnt < 4) begin u_val[u_cnt] = o_u_rdy; u_cyc[u_cnt] = cyc; u_data[u_cnt] = o_resp_data; end
            u_cnt++;
        end
        i_snoop_found = cfg_found ? prev_search : 2'b00;
        i_snoop_data0 = prev_search[0] ? cfg_sdata : ~cfg_sdata;
        i_snoop_data1 = prev_search[1] ? cfg_sdata : ~cfg_sdata;
        prev_search   = o_cpu_search;
        mcount        = (o_mem_re || o_mem_we) ? mcount + 1 : 0;
        i_mem_rdy     = (mcount == cfg_mwait + 1);
        i_mem_rdata   = i_mem_rdy ? cfg_mdata : 16'hDEAD;
        if (o_u_rdy[0]) drop(0);
        if (o_u_rdy[1]) drop(1);
    endtask

    task automatic wait_u(input string name, input int n, input int bound);
        for (int k = 0; k < bound && u_cnt < n; k++) tick();
        chk({name, "_urdy_count"}, 32'(u_cnt), 32'(n));
    endtask

    task automatic run_vec(input int i, input vec_t v);
        string p;
        p = $sformatf("v%0d", i);
        clear_mon();
        cfg_found = v.found; cfg_sdata = v.sdata; cfg_mwait = v.mwait; cfg_mdata = v.mdata;
        i_req_addr0  = v.core ? ~v.addr : v.addr;
        i_req_addr1  = v.core ? v.addr : ~v.addr;
        i_req_wdata0 = v.core ? ~v.wdata : v.wdata;
        i_req_wdata1 = v.core ? v.wdata : ~v.wdata;
        {i_req_wb[v.core], i_req_wr_miss[v.core], i_req_rd_miss[v.core], i_req_inval[v.core]} = v.kind;
        wait_u(p, 1, 40);
        chk({p, "_grant"}, 32'(g_val[0]), 32'(v.e_grant));
        chk({p, "_grant_cycle"}, 32'(g_cyc[0]), 32'd1);
        chk({p, "_grant_pulses"}, 32'(g_cnt), 32'd1);
        chk({p, "_cpu_search"}, 32'(s_val), 32'(v.e_search));
        chk({p, "_search_pulses"}, 32'(s_cnt), 32'(v.e_search != 2'b00));
        chk({p, "_snoop_inval"}, 32'(s_inv), 32'(v.e_inval));
        if (v.e_search != 2'b00) chk({p, "_snoop_addr"}, 32'(s_addr), 32'(v.addr));
        chk({p, "_mem_re"}, 32'(re_seen), 32'(v.e_re));
        chk({p, "_mem_we"}, 32'(we_seen), 32'(v.e_we));
        if (v.e_re || v.e_we) chk({p, "_mem_addr"}, 32'(m_addr), 32'(v.addr));
        if (v.e_we) chk({p, "_mem_wdata"}, 32'(m_wdata), 32'(v.e_wdata));
        chk({p, "_u_rdy"}, 32'(u_val[0]), v.core ? 32'h2 : 32'h1);
        chk({p, "_latency"}, 32'(u_cyc[0]), 32'(v.e_lat));
        chk({p, "_resp_data"}, 32'(u_data[0]), 32'(v.e_resp));
        tick(); tick();
    endtask

    initial begin
        i_req_rd_miss = 2'b00; i_req_wr_miss = 2'b00; i_req_inval = 2'b00; i_req_wb = 2'b00;
        i_req_addr0 = '0; i_req_addr1 = '0; i_req_wdata0 = '0; i_req_wdata1 = '0;
        i_snoop_found = 2'b00; i_snoop_data0 = '0; i_snoop_data1 = '0; i_mem_rdata = '0; i_mem_rdy = 1'b0;
        vecs[0] = '{1'b0, 4'h2, 13'h0104, 16'h0000, 1'b0, 16'h0000, 2, 16'hBEEF, 2'b01, 2'b10, 2'b00, 1'b1, 1'b0, 16'h0000, 6, 16'hBEEF};
        vecs[1] = '{1'b1, 4'h4, 13'h0020, 16'h0000, 1'b1, 16'h1234, 0, 16'h0000, 2'b10, 2'b01, 2'b01, 1'b0, 1'b0, 16'h0000, 3, 16'h1234};
        vecs[2] = '{1'b1, 4'h1, 13'h0008, 16'h0000, 1'b0, 16'h0000, 0, 16'h0000, 2'b10, 2'b01, 2'b01, 1'b0, 1'b0, 16'h0000, 2, 16'h0000};
        vecs[3] = '{1'b0, 4'h8, 13'h0040, 16'hA5A5, 1'b0, 16'h0000, 1, 16'h0000, 2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 16'hA5A5, 3, 16'h0000};
`ifdef SHARE_WRITEBACK_EN
        vecs[4] = '{1'b1, 4'h2, 13'h1FFF, 16'h3333, 1'b1, 16'h5678, 0, 16'h0000, 2'b10, 2'b01, 2'b00, 1'b0, 1'b1, 16'h5678, 4, 16'h5678};
`else
        vecs[4] = '{1'b1, 4'h2, 13'h1FFF, 16'h3333, 1'b1, 16'h5678, 0, 16'h0000, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 16'h0000, 3, 16'h5678};
`endif
        vecs[5] = '{1'b0, 4'h4, 13'h0ABC, 16'h0000, 1'b0, 16'h0000, 0, 16'h0F0F, 2'b01, 2'b10, 2'b10, 1'b1, 1'b0, 16'h0000, 4, 16'h0F0F};
        vecs[6] = '{1'b1, 4'h8, 13'h1FFF, 16'hFFFF, 1'b0, 16'h0000, 0, 16'h0000, 2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 16'hFFFF, 2, 16'h0000};

        tick(); tick();
        chk("reset_strobes", 32'({o_grant, o_u_rdy, o_cpu_search, o_snoop_inval, o_mem_re, o_mem_we}), 32'h0);
        chk("reset_resp_snoop", 32'({o_resp_data, o_snoop_addr}), 32'h0);
        chk("reset_mem_bus", 32'({o_mem_addr, o_mem_wdata}), 32'h0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // simultaneous read misses right after reset: core0 first, then core1, then core0 wins the next tie
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        clear_mon();
        cfg_found = 1'b0; cfg_mwait = 0; cfg_mdata = 16'h1111;
        i_req_addr0 = 13'h0100; i_req_addr1 = 13'h0200; i_req_rd_miss = 2'b11;
        wait_u("tie1", 2, 40);
        chk("tie1_grant0", 32'(g_val[0]), 32'h1);
        chk("tie1_grant0_cycle", 32'(g_cyc[0]), 32'd1);
        chk("tie1_urdy0", 32'(u_val[0]), 32'h1);
        chk("tie1_urdy0_cycle", 32'(u_cyc[0]), 32'd4);
        chk("tie1_grant1", 32'(g_val[1]), 32'h2);
        chk("tie1_grant1_cycle", 32'(g_cyc[1]), 32'd6);
        chk("tie1_urdy1", 32'(u_val[1]), 32'h2);
        chk("tie1_urdy1_cycle", 32'(u_cyc[1]), 32'd9);
        chk("tie1_resp1", 32'(u_data[1]), 32'h1111);
        tick();
        clear_mon();
        i_req_rd_miss = 2'b11;
        wait_u("tie2", 2, 40);
        chk("tie2_grant0", 32'(g_val[0]), 32'h1);
        chk("tie2_grant1", 32'(g_val[1]), 32'h2);
        tick();

        // writeback and read miss from the same core: writeback goes first
        clear_mon();
        cfg_mdata = 16'h7777;
        i_req_addr0 = 13'h0040; i_req_wdata0 = 16'hA5A5; i_req_wb = 2'b01; i_req_rd_miss = 2'b01;
        wait_u("wbrd", 2, 40);
        chk("wbrd_mem_wdata", 32'(m_wdata), 32'hA5A5);
        chk("wbrd_urdy0_cycle", 32'(u_cyc[0]), 32'd2);
        chk("wbrd_resp0", 32'(u_data[0]), 32'h0);
        chk("wbrd_grant1_cycle", 32'(g_cyc[1]), 32'd4);
        chk("wbrd_urdy1_cycle", 32'(u_cyc[1]), 32'd7);
        chk("wbrd_resp1", 32'(u_data[1]), 32'h7777);
        chk("wbrd_mem_re", 32'(re_seen), 32'h1);
        tick();

        // async reset while memory read is outstanding
        clear_mon();
        cfg_mwait = 20; cfg_mdata = 16'hBEEF;
        i_req_addr0 = 13'h0104; i_req_rd_miss = 2'b01;
        for (int k = 0; k < 10 && !re_seen; k++) tick();
        chk("arst_reached_memrd", 32'(re_seen), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_strobes", 32'({o_grant, o_u_rdy, o_cpu_search, o_snoop_inval, o_mem_re, o_mem_we}), 32'h0);
        chk("arst_mem_bus", 32'({o_mem_addr, o_mem_wdata}), 32'h0);
        tick(); tick();
        chk("arst_no_urdy", 32'(u_cnt), 32'h0);
        rst_n = 1'b1;
        clear_mon();
        cfg_mwait = 0;
        wait_u("arst_retry", 1, 20);
        chk("arst_retry_grant", 32'(g_val[0]), 32'h1);
        chk("arst_retry_grant_cycle", 32'(g_cyc[0]), 32'd1);
        chk("arst_retry_latency", 32'(u_cyc[0]), 32'd4);
        chk("arst_retry_resp", 32'(u_data[0]), 32'hBEEF);
        chk("arst_retry_addr", 32'(m_addr), 32'h0104);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
